cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Shares the single physical-memory/L2 line port between the instruction cache (fetch fills) and the data cache (fills and writebacks) of the RV32I pipeline.
- Sits between the two L1 cache controllers and the memory interface.
- Latches each granted request and sequences it to completion with an FSM.
- Round-robin fairness when both requesters are pending.

Parameters:
- ADDR_WIDTH, 32, byte address width of line requests (line-aligned; low 5 bits passed through unchanged)
- LINE_WIDTH, 256, cache line width in bits

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_read  in  1  I-cache line read request, held until i_resp
- i_address  in  ADDR_WIDTH  I-cache line address
- i_rdata  out  LINE_WIDTH  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request, held until d_resp
- d_write  in  1  D-cache line writeback request, held until d_resp
- d_address  in  ADDR_WIDTH  D-cache line address
- d_wdata  in  LINE_WIDTH  D-cache writeback line
- d_rdata  out  LINE_WIDTH  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  memory read strobe, held until mem_resp
- mem_write  out  1  memory write strobe, held until mem_resp
- mem_address  out  ADDR_WIDTH  memory line address
- mem_wdata  out  LINE_WIDTH  memory write line
- mem_rdata  in  LINE_WIDTH  memory read line, valid with mem_resp
- mem_resp  in  1  memory completion pulse
- busy  out  1  high while a transaction is outstanding (I_BUSY or D_BUSY)

Behaviour:
- States: IDLE, I_BUSY, D_BUSY, DONE.
- Reset, asynchronous and active-low, forces:
  - state = IDLE, last_grant = I (so D wins the first tie)
  - all mem_* strobes, i_resp, d_resp and busy = 0
  - latched address and wdata = 0; i_rdata and d_rdata = 0
- Reset mid-transaction abandons it. No resp is issued; memory strobes drop asynchronously.

Arbitration (IDLE):
- d_pending = d_read | d_write.
- Only i_read pending: go to I_BUSY.
- Only d_pending: go to D_BUSY.
- Both pending: grant the requester not in last_grant, then update last_grant.
- On the grant edge, latch:
  - address
  - op: write only if D was granted with d_write = 1
  - d_wdata, when D is granted
- If d_read and d_write are both high, treat it as a write (writeback precedes fill).
- Nothing pending: stay in IDLE, all outputs 0.

I_BUSY / D_BUSY:
- mem_read / mem_write are driven from registered state and the latched op; mem_address and mem_wdata come from the latches.
- Requester inputs are ignored after the grant, so changes to them do not disturb the transaction.
- On mem_resp:
  - capture mem_rdata into the granted requester's rdata register (reads only; writes leave rdata unchanged)
  - pulse that requester's resp for exactly the following cycle
  - move to DONE
- mem_resp in IDLE or DONE is ignored.

DONE:
- The resp pulse is high in this cycle, and mem strobes are 0.
- Always returns to IDLE. This gives one cycle of turnaround so a stale held request is not re-granted.

Timing:
- Request high at edge N in IDLE: mem strobe high from cycle N+1.
- mem_resp at edge M: resp high during cycle M+1; earliest next grant at edge M+2.
- Minimum spacing is 3 cycles between back-to-back grants plus memory latency.

Other guarantees:
- mem_read and mem_write are never high together.
- i_resp and d_resp are never high together.
- i_rdata and d_rdata hold their last value between transactions.
- Pending requests are never starved: under continuous contention, grants alternate I, D, I, D.

Test Plan:
- Single I read: i_read = 1, i_address = 0x0000_1040; memory responds after 4 cycles with 0xAA..AA. Required: mem_read = 1 and mem_address = 0x1040 from the next cycle; i_rdata = 0xAA..AA; i_resp pulses 1 cycle; d_resp stays 0.
- Writeback then fill: d_write = 1, d_address = 0x0000_2000, d_wdata = 0x5555..55; after d_resp, switch to d_read at 0x3000. Required: mem_write with wdata 0x55..55 first, then a separate mem_read at 0x3000, separated by the DONE cycle.
- Simultaneous contention after reset: i_read and d_read both held for 4 transactions. Required: grant order D, I, D, I; each resp exactly one pulse; no strobe overlap.
- Request change mid-transaction: during D_BUSY, change d_address to 0xFFFF_FFE0. Required: mem_address stays at the latched value until mem_resp.
- Async reset mid-transaction: assert rst low between clock edges during I_BUSY. Required: mem_read drops immediately; no i_resp. After release with i_read still high, the transaction restarts cleanly.
- Spurious mem_resp in IDLE. Required: no resp pulse, state stays IDLE, rdata unchanged.

Source files
------------

// File: rtl/cache_arbiter.sv
// Shares one memory line port between the I-cache and the D-cache.
// Each grant is latched and run to completion, then a one-cycle DONE turnaround; ties alternate.
module cache_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  last_d_q, last_d_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
   logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic                  i_resp_q, i_resp_d;
   logic                  d_resp_q, d_resp_d;
   logic                  d_pending_s;
   logic                  grant_d_s;
   logic                  in_busy_s;

   // Next-state, grant decision and transaction latches.
   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_resp_d    = 1'b0;
      d_resp_d    = 1'b0;
      d_pending_s = d_read | d_write;
      grant_d_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_read | d_pending_s) begin
               // On a tie the side that did not win last time gets the port.
               grant_d_s = d_pending_s & (~i_read | ~last_d_q);
               last_d_d  = grant_d_s;
               if (grant_d_s) begin
                  state_d = D_BUSY;
                  addr_d  = d_address;
                  write_d = d_write;
                  wdata_d = d_wdata;
               end else begin
                  state_d = I_BUSY;
                  addr_d  = i_address;
                  write_d = 1'b0;
               end
            end else begin
               state_d = IDLE;
            end
         end
         I_BUSY: begin
            if (mem_resp) begin
               state_d   = DONE;
               i_resp_d  = 1'b1;
               i_rdata_d = mem_rdata;
            end else begin
               state_d = I_BUSY;
            end
         end
         D_BUSY: begin
            if (mem_resp) begin
               state_d  = DONE;
               d_resp_d = 1'b1;
               if (!write_q) begin
                  d_rdata_d = mem_rdata;
               end else begin
                  d_rdata_d = d_rdata_q;
               end
            end else begin
               state_d = D_BUSY;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and latch registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         last_d_q  <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_resp_q  <= 1'b0;
         d_resp_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_d_q  <= last_d_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         i_resp_q  <= i_resp_d;
         d_resp_q  <= d_resp_d;
      end
   end

   // Strobes decode straight from state so they fall together with an async reset.
   assign in_busy_s   = (state_q == I_BUSY) || (state_q == D_BUSY);
   assign busy        = in_busy_s;
   assign mem_read    = in_busy_s & ~write_q;
   assign mem_write   = in_busy_s & write_q;
   assign mem_address = in_busy_s ? addr_q : '0;
   assign mem_wdata   = (in_busy_s & write_q) ? wdata_q : '0;
   assign i_rdata     = i_rdata_q;
   assign d_rdata     = d_rdata_q;
   assign i_resp      = i_resp_q;
   assign d_resp      = d_resp_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter against a transaction-level model of arbitration,
// latching, DONE turnaround and response delivery.
module tb_cache_arbiter;
   localparam int AW = 32;
   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_read, i_resp, d_read, d_write, d_resp;
   logic [AW-1:0] i_address, d_address, mem_address;
   logic [LW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
   logic          mem_read, mem_write, mem_resp, busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy)
   );

   // Reference model: one outstanding transaction record plus turnaround flag.
   bit            m_active, m_write, m_turn, m_last_d;
   int            m_who, m_resp_who;
   logic [AW-1:0] m_addr;
   logic [LW-1:0] m_wdata, m_i_rdata, m_d_rdata;

   // Stimulus controls
   int i_pct, d_pct, lat, resp_cnt;
   bit mem_en, d_reads_only, rec_order;
   int order[$];

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic model_reset();
      m_active = 0; m_write = 0; m_turn = 0; m_last_d = 0;
      m_who = 0; m_resp_who = 0;
      m_addr = '0; m_wdata = '0; m_i_rdata = '0; m_d_rdata = '0;
   endtask

   // Apply what happened at the rising edge just passed, using the inputs presented there.
   task automatic model_edge();
      bit dp, give_d;
      if (!rst) begin
         model_reset();
         return;
      end
      m_resp_who = 0;
      if (m_turn) begin
         m_turn = 0;
      end else if (m_active) begin
         if (mem_resp) begin
            if (!m_write) begin
               if (m_who == 2) m_d_rdata = mem_rdata;
               else m_i_rdata = mem_rdata;
            end
            m_resp_who = m_who;
            m_active = 0;
            m_turn = 1;
         end
      end else begin
         dp = d_read || d_write;
         if (i_read || dp) begin
            give_d   = dp && (!i_read || !m_last_d);
            m_last_d = give_d;
            m_active = 1;
            m_who    = give_d ? 2 : 1;
            m_addr   = give_d ? d_address : i_address;
            m_write  = give_d && d_write;
            if (give_d) m_wdata = d_wdata;
         end
      end
   endtask

   task automatic check_outputs();
      check("busy", busy, m_active);
      check("mem_read", mem_read, m_active && !m_write);
      check("mem_write", mem_write, m_active && m_write);
      if (m_active) check("mem_address", mem_address, m_addr);
      if (m_active && m_write) check("mem_wdata", mem_wdata, m_wdata);
      check("i_resp", i_resp, m_resp_who == 1);
      check("d_resp", d_resp, m_resp_who == 2);
      check("i_rdata", i_rdata, m_i_rdata);
      check("d_rdata", d_rdata, m_d_rdata);
   endtask

   // Requesters and memory react to what they see at the falling edge.
   task automatic drive();
      int op;
      if (i_resp) i_read = 1'b0;
      else if (!i_read && $urandom_range(99) < i_pct) begin
         i_read = 1'b1; i_address = $urandom();
      end else if ($urandom_range(7) == 0) i_address = $urandom();

      if (d_resp) begin
         d_read = 1'b0; d_write = 1'b0;
      end else if (!(d_read || d_write) && $urandom_range(99) < d_pct) begin
         op = d_reads_only ? 0 : $urandom_range(2);
         d_read = (op != 1); d_write = (op != 0);
         d_address = $urandom(); d_wdata = rand_line();
      end else if ($urandom_range(7) == 0) begin
         d_address = $urandom(); d_wdata = rand_line();
      end

      if ((mem_read || mem_write) && mem_en && !mem_resp) begin
         if (lat == 0) begin
            mem_resp = 1'b1; mem_rdata = rand_line(); lat = $urandom_range(4);
         end else begin
            mem_resp = 1'b0; lat--;
         end
      end else begin
         mem_resp  = mem_en && ($urandom_range(15) == 0);
         mem_rdata = rand_line();
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_edge();
      check_outputs();
      if (i_resp) resp_cnt++;
      if (rec_order && i_resp) order.push_back(1);
      if (rec_order && d_resp) order.push_back(2);
      drive();
   endtask

   initial begin
      rst = 1'b0;
      i_read = 1'b1; i_address = 32'h0000_1040;
      d_read = 1'b1; d_write = 1'b0; d_address = 32'h0000_3000; d_wdata = '0;
      mem_resp = 1'b0; mem_rdata = '0;
      i_pct = 100; d_pct = 100; d_reads_only = 1; mem_en = 1; lat = 3;
      rec_order = 1; resp_cnt = 0;
      model_reset();
      @(negedge clk);
      check_outputs();
      rst = 1'b1;

      // Continuous contention straight out of reset: D must win first, then alternate.
      repeat (60) step();
      rec_order = 0;
      check("order_len", order.size() >= 4, 1'b1);
      for (int k = 0; k < 4 && k < order.size(); k++)
         check($sformatf("grant_order_%0d", k), order[k], (k % 2 == 0) ? 2 : 1);

      // Mixed random traffic with reads, writebacks, read+write combos and spurious mem_resp.
      i_pct = 30; d_pct = 30; d_reads_only = 0;
      repeat (1500) step();

      // Drain, then hold an I read in flight and pull reset between edges.
      i_pct = 0; d_pct = 0;
      repeat (30) step();
      i_pct = 100; mem_en = 0;
      begin
         int k = 0;
         while (!(m_active && m_who == 1) && k < 50) begin
            step();
            k++;
         end
      end
      check("pre_rst_mem_read", mem_read, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("rst_mem_read", mem_read, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_i_resp", i_resp, 1'b0);
      check("rst_i_rdata", i_rdata, '0);
      model_reset();
      @(negedge clk);
      model_edge();
      check_outputs();
      rst = 1'b1;
      i_pct = 0; mem_en = 1; lat = 2; resp_cnt = 0;
      repeat (40) step();
      check("restart_i_resp_count", resp_cnt, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
